// File: rtl/div_unit.sv
// Iterative RV32M divider: radix-2 restoring, one quotient bit per clock.
// Operands are reduced to magnitudes and the sign is restored in a single FIX cycle.
module div_unit #(
    parameter int BW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [BW-1:0] d1,
    input  logic [BW-1:0] d2,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] res
);

    localparam int CW = $clog2(BW) + 1;
    localparam logic [BW-1:0] MIN_NEG = {1'b1, {(BW-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [BW-1:0] quo_q, quo_d;
    logic [BW:0]   rem_q, rem_d;
    logic [BW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic [BW-1:0] res_q, res_d;

    logic          in_signed;
    logic          in_overflow;
    logic [BW-1:0] d1_mag;
    logic [BW-1:0] d2_mag;
    logic [BW:0]   rem_shift;
    logic [BW:0]   trial;
    logic [BW-1:0] fix_sel;
    logic          fix_neg;

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign res  = res_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        res_d   = res_q;

        // op[0]=0 selects the signed flavours (DIV/REM), op[1]=1 the remainder.
        in_signed   = ~op[0];
        in_overflow = in_signed && (d1 == MIN_NEG) && (d2 == {BW{1'b1}});
        d1_mag      = (in_signed && d1[BW-1]) ? (~d1 + BW'(1)) : d1;
        d2_mag      = (in_signed && d2[BW-1]) ? (~d2 + BW'(1)) : d2;

        rem_shift = {rem_q[BW-1:0], quo_q[BW-1]};
        trial     = rem_shift - {1'b0, div_q};

        fix_sel = op_q[1] ? rem_q[BW-1:0] : quo_q;
        fix_neg = ~op_q[0] && (op_q[1] ? r_neg_q : q_neg_q);

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (start) begin
                        op_d = op;
                        if (d2 == '0) begin
                            res_d   = op[1] ? d1 : {BW{1'b1}};
                            state_d = S_DONE;
                        end else if (in_overflow) begin
                            res_d   = op[1] ? '0 : d1;
                            state_d = S_DONE;
                        end else begin
                            quo_d   = d1_mag;
                            div_d   = d2_mag;
                            rem_d   = '0;
                            cnt_d   = '0;
                            q_neg_d = d1[BW-1] ^ d2[BW-1];
                            r_neg_d = d1[BW-1];
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // trial[BW] is the borrow: clear means the divisor fits.
                    if (!trial[BW]) begin
                        rem_d = trial;
                        quo_d = {quo_q[BW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift;
                        quo_d = {quo_q[BW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    res_d   = fix_neg ? (~fix_sel + BW'(1)) : fix_sel;
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
module tb_div_unit;

    localparam int BW = 32;
    // Edges counted from the accept edge inclusive: special cases finish on the
    // accept edge itself, normal ops on edge N+BW+1.
    localparam int LAT_SPECIAL = 1;
    localparam int LAT_NORMAL  = BW + 2;
    localparam int BUSY_NORMAL = BW + 1;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [1:0]    op;
    logic [BW-1:0] d1;
    logic [BW-1:0] d2;
    logic          flush;
    logic          busy;
    logic          done;
    logic [BW-1:0] res;

    int errors = 0;
    int checks = 0;

    div_unit #(.BW(BW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .d1      (d1),
        .d2      (d2),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .res     (res)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]    op;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] exp;
        int            lat;
    } vec_t;

    function automatic logic [BW-1:0] ref_div(input logic [1:0] o, input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [BW-1:0] a,
                                   input logic [BW-1:0] b);
        if (b == 0) return LAT_SPECIAL;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; counts edges and busy cycles.
    task automatic run_op(input logic [1:0] o, input logic [BW-1:0] a, input logic [BW-1:0] b,
                          output logic [BW-1:0] r, output int lat, output int bcnt,
                          output logic seen);
        @(negedge clock);
        op = o; d1 = a; d2 = b; start = 1'b1;
        @(posedge clock);
        lat = 1;
        bcnt = 0;
        @(negedge clock);
        start = 1'b0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        seen = done;
        r = res;
    endtask

    task automatic run_and_check(input string name, input logic [1:0] o,
                                 input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic [BW-1:0] exp;
        int lat;
        int bcnt;
        int exp_lat;
        logic seen;
        exp = ref_div(o, a, b);
        exp_lat = ref_lat(o, a, b);
        run_op(o, a, b, r, lat, bcnt, seen);
        check({name, "_done"}, 32'(seen), 32'd1);
        check({name, "_res"}, r, exp);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        if (exp_lat == LAT_NORMAL) check({name, "_busy"}, 32'(bcnt), 32'(BUSY_NORMAL));
        $display("op=%0d d1=%h d2=%h res=%h exp=%h lat=%0d busy=%0d", o, a, b, r, exp, lat, bcnt);
    endtask

    initial begin
        vec_t vecs[8];
        logic [BW-1:0] r;
        int lat;
        int bcnt;
        int dcount;
        logic seen;

        vecs[0] = '{2'b01, 32'd100,       32'd7,         32'd14,        LAT_NORMAL};
        vecs[1] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORMAL};
        vecs[2] = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORMAL};
        vecs[3] = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPECIAL};
        vecs[4] = '{2'b11, 32'd5,         32'd0,         32'd5,         LAT_SPECIAL};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL};
        vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LAT_SPECIAL};
        vecs[7] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORMAL};

        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; d1 = '0; d2 = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_res", res, 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bcnt, seen);
            check($sformatf("vec%0d_done", i), 32'(seen), 32'd1);
            check($sformatf("vec%0d_res", i), r, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat == LAT_NORMAL)
                check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(BUSY_NORMAL));
            $display("vec%0d op=%0d d1=%h d2=%h res=%h lat=%0d busy=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bcnt);
        end

        // DIVU 1000/3 with a conflicting start re-pulsed mid-operation
        @(negedge clock);
        op = 2'b01; d1 = 32'd1000; d2 = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        op = 2'b00; d1 = 32'd7; d2 = 32'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dcount = 0;
        while (!done && dcount < 100) begin
            @(negedge clock);
            dcount++;
        end
        check("repulse_done", 32'(done), 32'd1);
        check("repulse_res", res, 32'd333);
        check("repulse_lat", 32'(dcount + 6), 32'(LAT_NORMAL));
        $display("repulse DIVU 1000/3 res=%h", res);

        // flush an in-flight op at cycle 10
        @(negedge clock);
        op = 2'b01; d1 = 32'd50; d2 = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_res", res, 32'd333);
        dcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcount++;
        end
        check("flush_no_done", 32'(dcount), 32'd0);
        $display("flush mid-op busy=%0d res=%h stray_done=%0d", busy, res, dcount);

        // flush beats start in the same cycle
        op = 2'b11; d1 = 32'd77; d2 = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush_prio_done", 32'(done), 32'd0);
        check("flush_prio_res", res, 32'd333);
        $display("flush+start same cycle done=%0d res=%h", done, res);

        // back-to-back: new start accepted in the DONE cycle
        run_op(2'b01, 32'd9, 32'd3, r, lat, bcnt, seen);
        check("b2b_first_done", 32'(seen), 32'd1);
        check("b2b_first_res", r, 32'd3);
        op = 2'b11; d1 = 32'd9; d2 = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        dcount = 1;
        while (!done && dcount < 100) begin
            @(negedge clock);
            dcount++;
        end
        check("b2b_second_res", res, 32'd1);
        check("b2b_second_lat", 32'(dcount), 32'(LAT_NORMAL));
        $display("b2b DIVU 9/3 -> REMU 9/4 res=%h lat=%0d", res, dcount);

        // asynchronous reset pulse mid-CALC
        @(negedge clock);
        op = 2'b01; d1 = 32'd12345; d2 = 32'd17; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", res, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcount++;
        end
        check("rst_no_done", 32'(dcount), 32'd0);
        $display("reset mid-CALC res=%h stray_done=%0d", res, dcount);

        // randomized ops against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [1:0] ro;
            logic [BW-1:0] ra;
            logic [BW-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = (n % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
            if (n % 7 == 0) ra = 32'h8000_0000;
            run_and_check($sformatf("rand%0d", n), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
